// File: rtl/instr_mem_resp.sv
// Instruction-side responder: word-addressed program RAM with a sequential load
// port, one-cycle fetch path and an IDLE/LOAD/RUN/FAULT mode FSM gating the PC.
module instr_mem_resp #(
    parameter logic [31:0] TEXT_BASE_ADDR = 32'h0040_0000,
    parameter int unsigned DEPTH_WORDS    = 16384,
    localparam int unsigned IDX_W         = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      fetch_addr,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             pc_en,
    input  logic             go,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    input  logic             ld_done,
    output logic             ld_ready,
    output logic [IDX_W:0]   ld_count,
    output logic [1:0]       fault,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_RUN   = 2'b10,
        S_FAULT = 2'b11
    } state_e;

    localparam logic [1:0]     F_NONE      = 2'b00;
    localparam logic [1:0]     F_MISALIGN  = 2'b01;
    localparam logic [1:0]     F_RANGE     = 2'b10;
    localparam logic [IDX_W:0] DEPTH_CNT   = DEPTH_WORDS[IDX_W:0];

    logic [31:0]      mem [DEPTH_WORDS];

    state_e           state_q, state_d;
    logic [1:0]       fault_q, fault_d;
    logic [IDX_W:0]   ld_count_q, ld_count_d;
    logic             instr_valid_q, instr_valid_d;
    logic [31:0]      instr_q;

    logic [31:0]      offset;
    logic [31:0]      word_off;
    logic             misaligned;
    logic             out_of_range;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_en;
    logic             wr_en;

    // Below-base addresses wrap the subtraction, so the explicit compare catches them.
    assign offset       = fetch_addr - TEXT_BASE_ADDR;
    assign word_off     = offset >> 2;
    assign misaligned   = |fetch_addr[1:0];
    assign out_of_range = (fetch_addr < TEXT_BASE_ADDR) || (word_off >= DEPTH_WORDS);
    assign rd_idx       = word_off[IDX_W-1:0];
    assign wr_idx       = ld_count_q[IDX_W-1:0];

    assign pc_en       = (state_q == S_RUN);
    assign ld_ready    = (state_q == S_LOAD) && (ld_count_q < DEPTH_CNT);
    assign state_o     = state_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign ld_count    = ld_count_q;

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        ld_count_d    = ld_count_q;
        instr_valid_d = 1'b0;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    ld_count_d = '0;
                end else if (go) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (ld_valid && ld_ready) begin
                    wr_en      = 1'b1;
                    ld_count_d = ld_count_q + 1'b1;
                end
                if (ld_done) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (misaligned) begin
                    state_d = S_FAULT;
                    fault_d = F_MISALIGN;
                end else if (out_of_range) begin
                    state_d = S_FAULT;
                    fault_d = F_RANGE;
                end else begin
                    rd_en         = 1'b1;
                    instr_valid_d = 1'b1;
                end
            end
            S_FAULT: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    fault_d    = F_NONE;
                    ld_count_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fault_q       <= F_NONE;
            ld_count_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fault_q       <= fault_d;
            ld_count_q    <= ld_count_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // RAM has no reset; a write presented during reset is suppressed so contents survive.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            mem[wr_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= '0;
        end else if (rd_en) begin
            instr_q <= mem[rd_idx];
        end
    end

endmodule

// File: doc/instr_mem_resp.md
# instr_mem_resp

Instruction-side responder for the single-cycle CPU: accepts the next fetch address driven by the PC/next-address logic and returns the 32-bit instruction word one cycle later from an internal word-addressed program RAM. Also provides a sequential program-load port (fed by the UART loader) and a small mode FSM that gates the CPU's PC enable and traps misaligned or out-of-range fetches. Sits between the fetch controller and the decoder.

## Interface
- TEXT_BASE_ADDR, 32'h0040_0000, byte address of program word 0
- DEPTH_WORDS, 16384, RAM depth in 32-bit words (power of two); IDX_W = $clog2(DEPTH_WORDS)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (rst == 0 resets on the next rising edge)
- fetch_addr  in  32  next-instruction byte address from the fetch controller
- instr  out  32  instruction word for the address sampled on the previous edge
- instr_valid  out  1  instr is a legal fetched word
- pc_en  out  1  enable to the PC/next-address logic
- go  in  1  pulse: leave IDLE and start execution
- ld_start  in  1  pulse: enter program-load mode
- ld_valid  in  1  ld_data holds a word to store
- ld_data  in  32  program word
- ld_done  in  1  pulse: end program load
- ld_ready  out  1  load port accepts a word this cycle
- ld_count  out  IDX_W+1  words written since ld_start
- fault  out  2  00 none, 01 misaligned, 10 out of range
- state_o  out  2  00 IDLE, 01 LOAD, 10 RUN, 11 FAULT

## Operation
- States: IDLE, LOAD, RUN, FAULT. Reset -> IDLE.
- IDLE: pc_en=0, instr_valid=0. ld_start -> LOAD (ld_count cleared to 0); else go -> RUN. ld_start wins if both asserted.
- LOAD: ld_ready = (ld_count < DEPTH_WORDS). On ld_valid && ld_ready: mem[ld_count] <= ld_data, ld_count++. ld_valid while full is dropped; ld_count saturates at DEPTH_WORDS. ld_done -> IDLE; a word presented with ld_done in the same cycle is written first. go ignored in LOAD.
- RUN: pc_en=1. Each edge samples fetch_addr; index = (fetch_addr - TEXT_BASE_ADDR) >> 2 (32-bit subtract).
  - fetch_addr[1:0] != 0 -> FAULT, fault=01.
  - else fetch_addr < TEXT_BASE_ADDR or index >= DEPTH_WORDS -> FAULT, fault=10.
  - misaligned takes priority over out-of-range.
  - else synchronous RAM read: instr <= mem[index], instr_valid <= 1.
- FAULT: pc_en=0, instr_valid=0, instr holds last good word, fault held. Only ld_start (-> LOAD, fault cleared) or reset leaves FAULT; go ignored.
- ld_start in RUN is ignored.
- RAM contents are not cleared by reset; reset mid-load returns to IDLE with words already written retained and ld_count=0.

## Timing
- Reset values: instr=0, instr_valid=0, pc_en=0, ld_ready=0, ld_count=0, fault=00, state_o=00.
- pc_en, ld_ready, state_o are decoded from current state (combinational from registers); instr, instr_valid, fault, ld_count registered.
- Fetch latency: fetch_addr sampled at edge N -> instr/instr_valid valid after edge N, usable throughout cycle N+1. One fetch per cycle, no bubbles in RUN.
- go in IDLE at edge N: state RUN and pc_en=1 after edge N; first instr_valid after edge N+1.
- Fault detected on edge N: state FAULT, pc_en=0, instr_valid=0 after edge N (faulting address never returns data).
- Load write at edge N is readable by a fetch sampled at edge N+1 or later.

## Test plan
- Reset: hold rst=0 two cycles with ld_valid/go toggling -> all outputs at reset values, state IDLE, RAM unchanged.
- Load 4 words 0x2002_0001..0x2002_0004 then ld_done, go, drive fetch_addr 0x0040_0000,04,08,0C on consecutive edges -> instr sequence 0x2002_0001..4 each one cycle later, instr_valid=1, ld_count=4.
- fetch_addr=0x0040_0006 in RUN -> fault=01, pc_en=0, instr_valid=0 next cycle; ld_start -> LOAD, fault=00.
- fetch_addr=0x003F_FFFC and 0x0041_0000 (DEPTH 16384) -> fault=10 each (separate runs); 0x0040_FFFC returns mem[16383].
- Fill to DEPTH_WORDS with ld_valid held, extra word 0xDEAD_BEEF -> ld_ready=0, ld_count=16384, mem[0] unchanged.
- ld_start and go same cycle in IDLE -> LOAD; ld_valid with ld_done same cycle -> word written, IDLE next; rst=0 mid-load -> IDLE, written words retained.
